// File: rtl/sof_transmit_if.sv
// Send-packet engine bus between the SOF scheduler (master/requester) and the
// shared packet sender with its arbiter (slave).
interface sof_transmit_if;
   logic        sendPacketArbiterReq;
   logic        sendPacketArbiterGnt;
   logic        sendPacketRdy;
   logic        sendPacketWEn;
   logic [3:0]  sendPacketPID;
   logic [10:0] frameNum;

   modport master (
      output sendPacketArbiterReq, sendPacketWEn, sendPacketPID, frameNum,
      input  sendPacketArbiterGnt, sendPacketRdy
   );

   modport slave (
      input  sendPacketArbiterReq, sendPacketWEn, sendPacketPID, frameNum,
      output sendPacketArbiterGnt, sendPacketRdy
   );
endinterface

// File: rtl/sof_transmit.sv
// Start-of-frame scheduler: waits for the frame timer to expire, wins the packet
// sender, launches the SOF token with the frame number and drives the pre-SOF guard.
module sof_transmit #(
   parameter logic [15:0] SOF_TX_TIME = 16'd47999,
   parameter logic [15:0] GUARD_TIME  = 16'd600,
   parameter logic [3:0]  SOF_PID     = 4'h5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SOFEnable,
   input  logic [15:0]           SOFTimer,
   sof_transmit_if.master        pkt,
   output logic                  SOFTimerClr,
   output logic                  SOFSent,
   output logic                  SOFGuard
);

   localparam logic [15:0] GUARD_START = SOF_TX_TIME - GUARD_TIME;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_RDY,
      WRITE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t      r_state;
   logic        r_req;
   logic        r_wen;
   logic [3:0]  r_pid;
   logic [10:0] r_frame;
   logic        r_clr;
   logic        r_sent;
   logic        r_guard;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_wen   <= 1'b0;
         r_pid   <= 4'h0;
         r_frame <= 11'd0;
         r_clr   <= 1'b0;
         r_sent  <= 1'b0;
         r_guard <= 1'b0;
      end else begin
         r_sent  <= 1'b0;
         // The timer still reads high in the Clr cycle; drop the guard right after it.
         r_guard <= SOFEnable && (SOFTimer >= GUARD_START) && !r_clr;
         case (r_state)
            IDLE: begin
               if (SOFEnable && (SOFTimer >= SOF_TX_TIME)) begin
                  r_req   <= 1'b1;
                  r_state <= REQ;
               end
            end
            REQ: begin
               if (!SOFEnable) begin
                  r_req   <= 1'b0;
                  r_state <= IDLE;
               end else if (pkt.sendPacketArbiterGnt) begin
                  r_state <= WAIT_RDY;
               end
            end
            WAIT_RDY: begin
               if (!SOFEnable) begin
                  r_req   <= 1'b0;
                  r_state <= IDLE;
               end else if (pkt.sendPacketRdy) begin
                  r_wen   <= 1'b1;
                  r_pid   <= SOF_PID;
                  r_clr   <= 1'b1;
                  r_state <= WRITE;
               end
            end
            WRITE: begin
               r_wen   <= 1'b0;
               r_clr   <= 1'b0;
               // A sender that drops Rdy immediately has already accepted the packet.
               r_state <= pkt.sendPacketRdy ? WAIT_BUSY : WAIT_DONE;
            end
            WAIT_BUSY: begin
               if (!pkt.sendPacketRdy) r_state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (pkt.sendPacketRdy) begin
                  r_req   <= 1'b0;
                  r_sent  <= 1'b1;
                  r_frame <= r_frame + 11'd1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pkt.sendPacketArbiterReq = r_req;
   assign pkt.sendPacketWEn        = r_wen;
   assign pkt.sendPacketPID        = r_pid;
   assign pkt.frameNum             = r_frame;
   assign SOFTimerClr              = r_clr;
   assign SOFSent                  = r_sent;
   assign SOFGuard                 = r_guard;

endmodule
